calc_seq_ctrl: RTL and testbench

//  Command sequencer upstream of the 8-bit calculator ALU. Buffers operation commands in a small FIFO.

---
 rtl/calc_pkg.sv | 72 +++++++
 rtl/calc_cmd_fifo.sv | 63 ++++++
 rtl/calc_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_calc_seq_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcode, flag, state and command definitions for the calculator sequencer.
// Also holds the rule that turns raw ALU output into a (data, flag, err) result.
package calc_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_DIV  = 4'h3;
   localparam logic [3:0] OP_SHL  = 4'h4;
   localparam logic [3:0] OP_SHR  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_XNOR = 4'h9;
   localparam logic [3:0] OP_NAND = 4'hA;
   localparam logic [3:0] OP_NOR  = 4'hB;

   localparam int FLG_CARRY = 1;
   localparam int FLG_OVF   = 2;
   localparam int FLG_LT    = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] sel;
      logic [7:0] a;
      logic [7:0] b;
      logic       use_acc;
   } cmd_t;

   typedef struct packed {
      logic [7:0] data;
      logic [3:0] flag;
      logic       err;
   } res_t;

   function automatic logic op_valid(input logic [3:0] sel);
      logic ok;
      case (sel)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SHL, OP_SHR,
         OP_AND, OP_OR, OP_XOR, OP_XNOR, OP_NAND, OP_NOR: ok = 1'b1;
         default:                                         ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Invalid opcodes and divide-by-zero override whatever the ALU produced.
   function automatic res_t resolve_result(input logic [3:0] sel,
                                           input logic [7:0] b,
                                           input logic [7:0] alu_out,
                                           input logic [3:0] alu_flag);
      res_t r;
      r.data = alu_out;
      r.flag = alu_flag;
      r.err  = 1'b0;
      if (!op_valid(sel)) begin
         r.data = 8'h00;
         r.flag = 4'h0;
         r.err  = 1'b1;
      end else if (sel == OP_DIV && b == 8'h00) begin
         r.data = 8'hFF;
         r.flag = 4'h0;
         r.err  = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/calc_cmd_fifo.sv
// Synchronous command FIFO; pointers wrap modulo DEPTH, count is one bit wider
// than the pointers so full and empty are unambiguous.
module calc_cmd_fifo
   import calc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  cmd_t push_data_i,
   input  logic pop_i,
   output cmd_t pop_data_o,
   output logic full_o,
   output logic empty_o
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   cmd_t          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o     = (count_q == FULL_CNT);
   assign empty_o    = (count_q == '0);
   assign do_push    = push_i && !full_o;
   assign do_pop     = pop_i && !empty_o;
   assign pop_data_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Command sequencer in front of the 8-bit calculator ALU: queues commands, issues
// one at a time, registers the result and keeps an accumulator for chaining.
module calc_seq_ctrl
   import calc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_sel,
   input  logic [7:0] cmd_a,
   input  logic [7:0] cmd_b,
   input  logic       cmd_use_acc,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_out,
   input  logic [3:0] alu_flag,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [3:0] res_flag,
   output logic       res_err,
   output logic [7:0] acc,
   output logic       busy,
   output state_t     dbg_state
);

   // Both ports: a transfer happens on a posedge where valid && ready; once valid
   // is raised the payload is held stable until that transfer.

   state_t     state_q, state_d;
   logic [7:0] op_a_q, op_a_d;
   logic [7:0] op_b_q, op_b_d;
   logic [3:0] op_sel_q, op_sel_d;
   res_t       res_q, res_d, res_now;
   logic [7:0] acc_q, acc_d;

   cmd_t       cmd_in, fifo_head;
   logic       fifo_full, fifo_empty, fifo_pop;

   assign cmd_in = '{sel: cmd_sel, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};

   calc_cmd_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (cmd_valid),
      .push_data_i (cmd_in),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign res_now = resolve_result(op_sel_q, op_b_q, alu_out, alu_flag);

   always_comb begin
      state_d  = state_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      op_sel_d = op_sel_q;
      res_d    = res_q;
      acc_d    = acc_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               op_a_d   = fifo_head.use_acc ? acc_q : fifo_head.a;
               op_b_d   = fifo_head.b;
               op_sel_d = fifo_head.sel;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            res_d = res_now;
            if (!res_now.err) acc_d = res_now.data;
            state_d = RESP;
         end
         RESP: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         op_sel_q <= '0;
         res_q    <= '0;
         acc_q    <= '0;
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         op_sel_q <= op_sel_d;
         res_q    <= res_d;
         acc_q    <= acc_d;
      end
   end

   // The op registers drive the ALU directly, so they hold the last issue outside EXEC.
   assign alu_a     = op_a_q;
   assign alu_b     = op_b_q;
   assign alu_sel   = op_sel_q;
   assign cmd_ready = !fifo_full;
   assign res_valid = (state_q == RESP);
   assign res_data  = res_q.data;
   assign res_flag  = res_q.flag;
   assign res_err   = res_q.err;
   assign acc       = acc_q;
   assign busy      = (state_q != IDLE) || !fifo_empty;
   assign dbg_state = state_q;

   a_res_stable: assert property (@(posedge clk) disable iff (!rst_n)
      res_valid && !res_ready |=> res_valid && $stable({res_data, res_flag, res_err}));

   a_full_blocks: assert property (@(posedge clk) disable iff (!rst_n)
      fifo_full |-> !cmd_ready);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Self-checking bench for calc_seq_ctrl with a behavioural ALU on the alu_* ports.
module tb_calc_seq_ctrl;
  import calc_pkg::*;

  localparam int W = 21;  // {err, flag[3:0], data[7:0], acc[7:0]}

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready, cmd_use_acc;
  logic [3:0] cmd_sel;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [3:0] alu_sel, alu_flag;
  logic       res_valid, res_ready, res_err, busy;
  logic [7:0] res_data, acc;
  logic [3:0] res_flag;
  state_t     dbg_state;

  int         n_cmp, n_fail;
  logic [W-1:0] exp_q[$];
  logic [7:0] model_acc;

  calc_seq_ctrl #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flag(res_flag), .res_err(res_err), .acc(acc), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [11:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] sel);
    logic [15:0] w;
    logic [7:0]  o;
    logic [3:0]  f;
    w = 16'h0; o = 8'h0; f = 4'h0;
    case (sel)
      OP_ADD:  begin w = {8'h00, a} + {8'h00, b}; o = w[7:0]; f[FLG_CARRY] = w[8]; end
      OP_SUB:  o = a - b;
      OP_MUL:  begin w = {8'h00, a} * {8'h00, b}; o = w[7:0]; f[FLG_OVF] = |w[15:8]; end
      OP_DIV:  o = (b == 8'h00) ? 8'hFF : a / b;
      OP_SHL:  o = a << b[2:0];
      OP_SHR:  o = a >> b[2:0];
      OP_AND:  o = a & b;
      OP_OR:   o = a | b;
      OP_XOR:  o = a ^ b;
      OP_XNOR: o = ~(a ^ b);
      OP_NAND: o = ~(a & b);
      OP_NOR:  o = ~(a | b);
      default: o = 8'h00;
    endcase
    if (sel <= OP_NOR) f[FLG_LT] = (a < b);
    return {f, o};
  endfunction

  always_comb {alu_flag, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    cmd_valid = 1'b0; cmd_sel = 4'h0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_use_acc = 1'b0;
    res_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    model_acc = 8'h00;
  endtask

  // Drives one command, waits for acceptance and records the expected result.
  task automatic push_cmd(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                          input logic use_acc);
    logic [7:0]  a_eff;
    logic [11:0] r;
    logic        err;
    logic [3:0]  flag;
    logic [7:0]  data;
    bit          ok;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_sel = sel; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: cmd_ready=%b, required 1 within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    a_eff = use_acc ? model_acc : a;
    r = alu_model(a_eff, b, sel);
    if (sel > OP_NOR) begin
      err = 1'b1; flag = 4'h0; data = 8'h00;
    end else if (sel == OP_DIV && b == 8'h00) begin
      err = 1'b1; flag = 4'h0; data = 8'hFF;
    end else begin
      err = 1'b0; flag = r[11:8]; data = r[7:0];
    end
    if (!err) model_acc = data;
    exp_q.push_back({err, flag, data, model_acc});
  endtask

  // Waits for res_valid, samples the result and completes the handshake if res_ready.
  task automatic wait_result(output logic [W-1:0] got, output bit ok);
    ok = 1'b0;
    got = '0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (res_valid) begin ok = 1'b1; break; end
    end
    if (ok) begin
      got = {res_err, res_flag, res_data, acc};
      if (res_ready) @(posedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({alu_a, alu_b, alu_sel} !== 20'h0) begin
      n_fail++; $display("FAIL reset_alu: got a=%h b=%h sel=%h, required 0", alu_a, alu_b, alu_sel);
    end
    n_cmp++;
    if ({res_data, res_flag, res_err, acc} !== 21'h0) begin
      n_fail++; $display("FAIL reset_res: got data=%h flag=%h err=%b acc=%h, required 0",
                         res_data, res_flag, res_err, acc);
    end
    n_cmp++;
    if ({res_valid, busy, cmd_ready} !== 3'b001 || dbg_state !== IDLE) begin
      n_fail++; $display("FAIL reset_ctrl: got valid=%b busy=%b ready=%b state=%0d, required 0 0 1 IDLE",
                         res_valid, busy, cmd_ready, dbg_state);
    end
  endtask

  task automatic test_single_op();
    logic [W-1:0] got, exp_v;
    res_ready = 1'b1;
    push_cmd(OP_ADD, 8'hF0, 8'h20, 1'b0);
    @(negedge clk);
    n_cmp++;
    if ({res_valid, busy} !== 2'b01) begin
      n_fail++; $display("FAIL single_t1: got valid=%b busy=%b, required 0 1", res_valid, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== EXEC || {alu_a, alu_b, alu_sel} !== {8'hF0, 8'h20, 4'h0}) begin
      n_fail++; $display("FAIL single_exec: got state=%0d a=%h b=%h sel=%h, required EXEC f0 20 0",
                         dbg_state, alu_a, alu_b, alu_sel);
    end
    @(negedge clk);
    n_cmp++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_latency: got res_valid=%b at t+3, required 1", res_valid);
    end
    n_cmp++;
    if ({res_data, res_flag, res_err, acc} !== {8'h10, 4'b0010, 1'b0, 8'h10}) begin
      n_fail++; $display("FAIL single_value: got data=%h flag=%b err=%b acc=%h, required 10 0010 0 10",
                         res_data, res_flag, res_err, acc);
    end
    got = {res_err, res_flag, res_data, acc};
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++; $display("FAIL single_sb: got %h required %h", got, exp_v);
    end
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({res_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_done: got valid=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic test_chain();
    logic [W-1:0] got, exp_v;
    bit ok;
    res_ready = 1'b1;
    push_cmd(OP_MUL, 8'h03, 8'h05, 1'b0);
    push_cmd(OP_ADD, 8'h55, 8'h01, 1'b1);
    for (int k = 0; k < 2; k++) begin
      wait_result(got, ok);
      n_cmp++;
      if (!ok || exp_q.size() == 0) begin
        n_fail++; $display("FAIL chain_sb%0d: got no result (ok=%b), required one", k, ok);
      end else begin
        exp_v = exp_q.pop_front();
        if (got !== exp_v) begin
          n_fail++; $display("FAIL chain_sb%0d: got %h required %h", k, got, exp_v);
        end
      end
      n_cmp++;
      if (got[15:8] !== ((k == 0) ? 8'h0F : 8'h10) || got[7:0] !== ((k == 0) ? 8'h0F : 8'h10)) begin
        n_fail++; $display("FAIL chain_val%0d: got data=%h acc=%h, required %h", k, got[15:8], got[7:0],
                           (k == 0) ? 8'h0F : 8'h10);
      end
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] got, exp_v;
    logic [7:0] acc_before;
    bit ok;
    res_ready = 1'b1;
    acc_before = model_acc;
    push_cmd(OP_DIV, 8'h09, 8'h00, 1'b0);
    wait_result(got, ok);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_cmp++;
    if (!ok || got !== exp_v) begin
      n_fail++; $display("FAIL div0_sb: got %h required %h (ok=%b)", got, exp_v, ok);
    end
    n_cmp++;
    if (got !== {1'b1, 4'h0, 8'hFF, acc_before}) begin
      n_fail++; $display("FAIL div0_val: got err=%b flag=%h data=%h acc=%h, required 1 0 ff %h",
                         got[20], got[19:16], got[15:8], got[7:0], acc_before);
    end
    push_cmd(4'hE, 8'h12, 8'h34, 1'b0);
    wait_result(got, ok);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_cmp++;
    if (!ok || got !== exp_v || got[20:8] !== {1'b1, 4'h0, 8'h00}) begin
      n_fail++; $display("FAIL badop: got %h required %h (ok=%b)", got, exp_v, ok);
    end
  endtask

  task automatic test_flags();
    logic [W-1:0] got, exp_v;
    bit ok;
    res_ready = 1'b1;
    push_cmd(OP_SUB, 8'h02, 8'h05, 1'b0);
    push_cmd(OP_MUL, 8'h20, 8'h10, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_result(got, ok);
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      n_cmp++;
      if (!ok || got !== exp_v) begin
        n_fail++; $display("FAIL flags_sb%0d: got %h required %h (ok=%b)", k, got, exp_v, ok);
      end
      n_cmp++;
      if ((k == 0 && (got[15:8] !== 8'hFD || got[16 + FLG_LT] !== 1'b1)) ||
          (k == 1 && (got[15:8] !== 8'h00 || got[16 + FLG_OVF] !== 1'b1))) begin
        n_fail++; $display("FAIL flags_val%0d: got data=%h flag=%b", k, got[15:8], got[19:16]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] got, exp_v;
    logic [12:0]  snap;
    bit ok, stable;
    res_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          push_cmd(4'($urandom_range(0, 11)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, res_valid} !== 3'b011 || dbg_state !== RESP) begin
          n_fail++; $display("FAIL bp_full: got ready=%b busy=%b valid=%b state=%0d, required 0 1 1 RESP",
                             cmd_ready, busy, res_valid, dbg_state);
        end
        snap = {res_data, res_flag, res_err};
        stable = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if ({res_data, res_flag, res_err} !== snap || res_valid !== 1'b1) stable = 1'b0;
        end
        n_cmp++;
        if (!stable) begin
          n_fail++; $display("FAIL bp_hold: got %h valid=%b, required %h held", {res_data, res_flag, res_err},
                             res_valid, snap);
        end
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          wait_result(got, ok);
          exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          n_cmp++;
          if (!ok || got !== exp_v) begin
            n_fail++; $display("FAIL bp_sb%0d: got %h required %h (ok=%b)", k, got, exp_v, ok);
          end
        end
      end
    join
  endtask

  task automatic test_back_to_back_random();
    logic [W-1:0] got, exp_v;
    bit ok;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_cmd(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
        end
      end
      begin
        for (int k = 0; k < 24; k++) begin
          res_ready = 1'b0;
          repeat ($urandom_range(0, 3)) @(negedge clk);
          res_ready = 1'b1;
          wait_result(got, ok);
          exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          n_cmp++;
          if (!ok || got !== exp_v) begin
            n_fail++; $display("FAIL rand_sb%0d: got %h required %h (ok=%b)", k, got, exp_v, ok);
          end
        end
      end
    join
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] got, exp_v;
    bit ok, stale;
    res_ready = 1'b0;
    push_cmd(OP_ADD, 8'h01, 8'h02, 1'b0);
    push_cmd(OP_OR, 8'h10, 8'h01, 1'b0);
    push_cmd(OP_AND, 8'hFF, 8'h0F, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (dbg_state !== RESP || {busy, res_valid} !== 2'b11) begin
      n_fail++; $display("FAIL rmid_pre: got state=%0d busy=%b valid=%b, required RESP 1 1",
                         dbg_state, busy, res_valid);
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({res_valid, busy, cmd_ready} !== 3'b001 || acc !== 8'h00) begin
      n_fail++; $display("FAIL rmid_post: got valid=%b busy=%b ready=%b acc=%h, required 0 0 1 00",
                         res_valid, busy, cmd_ready, acc);
    end
    rst_n = 1'b1;
    exp_q.delete();
    model_acc = 8'h00;
    res_ready = 1'b1;
    stale = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin
      n_fail++; $display("FAIL rmid_stale: got a result or busy after reset, required none");
    end
    push_cmd(OP_ADD, 8'hAA, 8'h07, 1'b1);
    wait_result(got, ok);
    exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
    n_cmp++;
    if (!ok || got !== exp_v || got[15:0] !== 16'h0707) begin
      n_fail++; $display("FAIL rmid_after: got %h required %h (ok=%b)", got, exp_v, ok);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single_op();
    test_chain();
    test_errors();
    test_flags();
    test_backpressure();
    test_back_to_back_random();
    test_reset_mid_op();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d unconsumed expected results, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
